// File: rtl/pipeline_controller.sv
// ID-stage decode, EXE/MEM destination tracking, forwarding selects, load-use stall and
// control-transfer flush for the 5-stage MIPS pipeline. Define CTRL_DEBUG_EN for the debug step FSM.
module pipeline_controller #(
    parameter int REG_ADDR_W = 5,
    parameter int STEP_CNT_W = 8,
    parameter int FWD_SRCS   = 2
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [31:0]                       inst,
    input  logic                              branch_eq,
`ifdef CTRL_DEBUG_EN
    input  logic                              debug_en,
    input  logic                              debug_step,
    input  logic [STEP_CNT_W-1:0]             debug_nsteps,
    output logic                              debug_busy,
`endif
    output logic [2:0]                        pc_src,
    output logic                              imm_ext,
    output logic [1:0]                        exe_a_src,
    output logic [1:0]                        exe_b_src,
    output logic [3:0]                        exe_alu_oper,
    output logic                              mem_ren,
    output logic                              mem_wen,
    output logic [1:0]                        wb_addr_src,
    output logic                              wb_data_src,
    output logic                              wb_wen,
    output logic                              unrecognized,
    output logic [$clog2(FWD_SRCS+1)-1:0]     fwd_a,
    output logic [$clog2(FWD_SRCS+1)-1:0]     fwd_b,
    output logic                              if_en,
    output logic                              id_en,
    output logic                              id_flush,
    output logic                              exe_bubble,
    output logic                              cpu_rst,
    output logic                              cpu_en
);
    localparam int FWD_W = $clog2(FWD_SRCS + 1);
    localparam logic [FWD_W-1:0] FWD_REG = FWD_W'(0);
    localparam logic [FWD_W-1:0] FWD_EXE = FWD_W'(1);
    localparam logic [FWD_W-1:0] FWD_MEM = FWD_W'(2);

    localparam logic [5:0] OP_RTYPE = 6'h00, OP_J = 6'h02, OP_JAL = 6'h03, OP_BEQ = 6'h04;
    localparam logic [5:0] OP_ADDI = 6'h08, OP_ANDI = 6'h0C, OP_ORI = 6'h0D;
    localparam logic [5:0] OP_LW = 6'h23, OP_SW = 6'h2B;
    localparam logic [5:0] FN_JR = 6'h08, FN_ADD = 6'h20, FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24, FN_OR = 6'h25, FN_SLT = 6'h2A;

    localparam logic [2:0] PC_NEXT = 3'd0, PC_JUMP = 3'd1, PC_JR = 3'd2, PC_BRANCH = 3'd3;
    localparam logic [3:0] ALU_ADD = 4'd0, ALU_SUB = 4'd1, ALU_AND = 4'd2, ALU_OR = 4'd3, ALU_SLT = 4'd4;
    localparam logic [1:0] SRC_RS = 2'd0, SRC_RT = 2'd0, SRC_IMM = 2'd1, SRC_LINK_A = 2'd1, SRC_LINK_B = 2'd2;
    localparam logic [1:0] WB_RD = 2'd0, WB_RT = 2'd1, WB_LINK = 2'd2;

    typedef struct packed {
        logic [REG_ADDR_W-1:0] dest;
        logic                  wen;
        logic                  is_load;
    } trk_t;

    logic [5:0]            opcode, funct;
    logic [REG_ADDR_W-1:0] rs, rt, rd, id_dest;
    logic [2:0]            dec_pc_src;
    logic                  reads_rt, xfer, stall;
    logic                  unused_shamt;
    trk_t                  trk_p0, trk_p1, trk_p2;

    assign opcode       = inst[31:26];
    assign funct        = inst[5:0];
    assign rs           = inst[21 +: REG_ADDR_W];
    assign rt           = inst[16 +: REG_ADDR_W];
    assign rd           = inst[11 +: REG_ADDR_W];
    assign unused_shamt = ^inst[10:6];

    function automatic logic [FWD_W-1:0] fwd_sel(input logic [REG_ADDR_W-1:0] src,
                                                 input trk_t exe, input trk_t mem);
        if (src != '0 && exe.wen && !exe.is_load && exe.dest == src) return FWD_EXE;
        if (src != '0 && mem.wen && mem.dest == src)                  return FWD_MEM;
        return FWD_REG;
    endfunction

    always_comb begin
        dec_pc_src   = PC_NEXT;
        imm_ext      = 1'b0;
        exe_a_src    = SRC_RS;
        exe_b_src    = SRC_RT;
        exe_alu_oper = ALU_ADD;
        mem_ren      = 1'b0;
        mem_wen      = 1'b0;
        wb_addr_src  = WB_RD;
        wb_data_src  = 1'b0;
        wb_wen       = 1'b0;
        unrecognized = 1'b0;
        reads_rt     = 1'b0;
        xfer         = 1'b0;
        case (opcode)
            OP_RTYPE: begin
                case (funct)
                    FN_JR:  begin dec_pc_src = PC_JR; xfer = 1'b1; end
                    FN_ADD: begin wb_wen = 1'b1; reads_rt = 1'b1; end
                    FN_SUB: begin exe_alu_oper = ALU_SUB; wb_wen = 1'b1; reads_rt = 1'b1; end
                    FN_AND: begin exe_alu_oper = ALU_AND; wb_wen = 1'b1; reads_rt = 1'b1; end
                    FN_OR:  begin exe_alu_oper = ALU_OR;  wb_wen = 1'b1; reads_rt = 1'b1; end
                    FN_SLT: begin exe_alu_oper = ALU_SLT; wb_wen = 1'b1; reads_rt = 1'b1; end
                    default: unrecognized = 1'b1;
                endcase
            end
            OP_J:   begin dec_pc_src = PC_JUMP; xfer = 1'b1; end
            OP_JAL: begin
                dec_pc_src  = PC_JUMP;
                xfer        = 1'b1;
                exe_a_src   = SRC_LINK_A;
                exe_b_src   = SRC_LINK_B;
                wb_addr_src = WB_LINK;
                wb_wen      = 1'b1;
            end
            OP_BEQ: begin
                // Branch resolved in ID: only a taken branch redirects and flushes.
                imm_ext      = 1'b1;
                exe_alu_oper = ALU_SUB;
                reads_rt     = 1'b1;
                xfer         = branch_eq;
                dec_pc_src   = branch_eq ? PC_BRANCH : PC_NEXT;
            end
            OP_ADDI: begin imm_ext = 1'b1; exe_b_src = SRC_IMM; wb_addr_src = WB_RT; wb_wen = 1'b1; end
            OP_ANDI: begin exe_b_src = SRC_IMM; exe_alu_oper = ALU_AND; wb_addr_src = WB_RT; wb_wen = 1'b1; end
            OP_ORI:  begin exe_b_src = SRC_IMM; exe_alu_oper = ALU_OR;  wb_addr_src = WB_RT; wb_wen = 1'b1; end
            OP_LW: begin
                imm_ext     = 1'b1;
                exe_b_src   = SRC_IMM;
                mem_ren     = 1'b1;
                wb_addr_src = WB_RT;
                wb_data_src = 1'b1;
                wb_wen      = 1'b1;
            end
            OP_SW:   begin imm_ext = 1'b1; exe_b_src = SRC_IMM; mem_wen = 1'b1; reads_rt = 1'b1; end
            default: unrecognized = 1'b1;
        endcase
    end

    always_comb begin
        case (wb_addr_src)
            WB_RT:   id_dest = rt;
            WB_LINK: id_dest = '1;
            default: id_dest = rd;
        endcase
    end

    assign stall      = trk_p1.is_load && (trk_p1.dest != '0) &&
                        ((trk_p1.dest == rs) || (trk_p1.dest == rt && reads_rt));
    assign pc_src     = stall ? PC_NEXT : dec_pc_src;
    assign id_flush   = xfer && !stall;
    assign if_en      = !stall;
    assign id_en      = !stall;
    assign exe_bubble = stall;
    assign fwd_a      = fwd_sel(rs, trk_p1, trk_p2);
    assign fwd_b      = fwd_sel(rt, trk_p1, trk_p2);

    // p0 -> p1 (EXE) -> p2 (MEM); a stalled slot enters EXE as a non-writing bubble
    assign trk_p0 = '{dest: id_dest, wen: wb_wen & ~stall, is_load: mem_ren & ~stall};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            trk_p1 <= '0;
            trk_p2 <= '0;
        end else if (cpu_en) begin
            trk_p1 <= trk_p0;
            trk_p2 <= trk_p1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) cpu_rst <= 1'b1;
        else     cpu_rst <= 1'b0;
    end

`ifdef CTRL_DEBUG_EN
    typedef enum logic [1:0] {RUN, HALT, STEP} dbg_state_t;

    dbg_state_t            state, state_next;
    logic [STEP_CNT_W-1:0] cnt, cnt_next;
    logic                  step_prev, run_en;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= RUN;
            cnt       <= '0;
            step_prev <= 1'b0;
        end else begin
            state     <= state_next;
            cnt       <= cnt_next;
            step_prev <= debug_step;
        end
    end

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        run_en     = 1'b0;
        case (state)
            RUN: begin
                run_en = 1'b1;
                if (debug_en) state_next = HALT;
            end
            HALT: begin
                if (!debug_en) begin
                    state_next = RUN;
                end else if (debug_step && !step_prev) begin
                    cnt_next   = (debug_nsteps == '0) ? STEP_CNT_W'(1) : debug_nsteps;
                    state_next = STEP;
                end
            end
            STEP: begin
                run_en   = 1'b1;
                cnt_next = cnt - STEP_CNT_W'(1);
                if (!debug_en)                   state_next = RUN;
                else if (cnt == STEP_CNT_W'(1))  state_next = HALT;
            end
            default: state_next = RUN;
        endcase
    end

    assign debug_busy = (state == STEP);
    assign cpu_en     = run_en && !cpu_rst;
`else
    localparam int unused_step_cnt_w = STEP_CNT_W;

    assign cpu_en = !cpu_rst;
`endif
endmodule

// File: tb/tb_pipeline_controller.sv
// Bench for pipeline_controller: directed hazard, transfer and reset cases, then random
// instruction streams scored against a producer-history model of the EXE/MEM stages.
`timescale 1ns/1ps
module tb_pipeline_controller;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] inst = '0;
    logic        branch_eq = 1'b0;
    logic [2:0]  pc_src;
    logic        imm_ext, mem_ren, mem_wen, wb_data_src, wb_wen, unrecognized;
    logic [1:0]  exe_a_src, exe_b_src, wb_addr_src, fwd_a, fwd_b;
    logic [3:0]  exe_alu_oper;
    logic        if_en, id_en, id_flush, exe_bubble, cpu_rst, cpu_en;
`ifdef CTRL_DEBUG_EN
    logic        debug_en = 1'b0;
    logic        debug_step = 1'b0;
    logic [7:0]  debug_nsteps = '0;
    logic        debug_busy;
`endif

    always #5 clk = ~clk;

    pipeline_controller #(.REG_ADDR_W(5), .STEP_CNT_W(8), .FWD_SRCS(2)) dut (
        .clk(clk), .rst(rst), .inst(inst), .branch_eq(branch_eq),
`ifdef CTRL_DEBUG_EN
        .debug_en(debug_en), .debug_step(debug_step), .debug_nsteps(debug_nsteps), .debug_busy(debug_busy),
`endif
        .pc_src(pc_src), .imm_ext(imm_ext), .exe_a_src(exe_a_src), .exe_b_src(exe_b_src),
        .exe_alu_oper(exe_alu_oper), .mem_ren(mem_ren), .mem_wen(mem_wen),
        .wb_addr_src(wb_addr_src), .wb_data_src(wb_data_src), .wb_wen(wb_wen),
        .unrecognized(unrecognized), .fwd_a(fwd_a), .fwd_b(fwd_b), .if_en(if_en), .id_en(id_en),
        .id_flush(id_flush), .exe_bubble(exe_bubble), .cpu_rst(cpu_rst), .cpu_en(cpu_en)
    );

    // Producer history: entry 0 is the instruction now in EXE, entry 1 the one in MEM.
    // A non-writing slot is recorded with dest 0, which can never be forwarded or stall.
    typedef struct { int dest; bit load; } prod_t;
    typedef struct { int pc, imm, a, b, alu, ren, mwen, wba, wbd, wbw, unrec, rrt, xfer, dest; } dec_t;

    prod_t       q[$];
    bit          exp_rst;
    int          n_pass = 0;
    int          n_total = 0;
    logic [31:0] cap_pc, cap_flush, cap_if, cap_bubble, cap_fa, cap_fb;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total = n_total + 1;
        assert (got === exp) n_pass = n_pass + 1;
        else $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    endtask

    function automatic logic [31:0] r_ins(input int fn, input int rd, input int rs, input int rt);
        return {6'h00, 5'(rs), 5'(rt), 5'(rd), 5'd0, 6'(fn)};
    endfunction

    function automatic logic [31:0] i_ins(input int op, input int rt, input int rs, input int imm);
        return {6'(op), 5'(rs), 5'(rt), 16'(imm)};
    endfunction

    function automatic logic [31:0] j_ins(input int op, input int tgt);
        return {6'(op), 26'(tgt)};
    endfunction

    task automatic reset_model();
        prod_t p;
        p.dest = 0;
        p.load = 0;
        q.delete();
        q.push_back(p);
        q.push_back(p);
    endtask

    function automatic int exp_fwd(input int src);
        if (src == 0) return 0;
        if (q[0].dest == src && !q[0].load) return 1;
        if (q[1].dest == src) return 2;
        return 0;
    endfunction

    function automatic dec_t expect_dec(input logic [31:0] i, input logic beq);
        dec_t d;
        int op, fn, rt, rd;
        d  = '{default: 0};
        op = int'(i[31:26]);
        fn = int'(i[5:0]);
        rt = int'(i[20:16]);
        rd = int'(i[15:11]);
        case (op)
            0: case (fn)
                   'h08: begin d.pc = 2; d.xfer = 1; end
                   'h20, 'h22, 'h24, 'h25, 'h2A: begin
                       d.alu = (fn == 'h22) ? 1 : (fn == 'h24) ? 2 : (fn == 'h25) ? 3 : (fn == 'h2A) ? 4 : 0;
                       d.wbw = 1; d.rrt = 1; d.dest = rd;
                   end
                   default: d.unrec = 1;
               endcase
            'h02: begin d.pc = 1; d.xfer = 1; end
            'h03: begin d.pc = 1; d.xfer = 1; d.a = 1; d.b = 2; d.wba = 2; d.wbw = 1; d.dest = 31; end
            'h04: begin d.imm = 1; d.alu = 1; d.rrt = 1; d.xfer = int'(beq); d.pc = beq ? 3 : 0; end
            'h08: begin d.imm = 1; d.b = 1; d.wba = 1; d.wbw = 1; d.dest = rt; end
            'h0C: begin d.b = 1; d.alu = 2; d.wba = 1; d.wbw = 1; d.dest = rt; end
            'h0D: begin d.b = 1; d.alu = 3; d.wba = 1; d.wbw = 1; d.dest = rt; end
            'h23: begin d.imm = 1; d.b = 1; d.ren = 1; d.wba = 1; d.wbd = 1; d.wbw = 1; d.dest = rt; end
            'h2B: begin d.imm = 1; d.b = 1; d.mwen = 1; d.rrt = 1; end
            default: d.unrec = 1;
        endcase
        return d;
    endfunction

    task automatic step(input logic [31:0] i, input logic beq, output bit stalled, output bit flushed);
        dec_t  d;
        prod_t p;
        int    rs, rt;
        bit    st;
        inst      = i;
        branch_eq = beq;
        #1;
        d  = expect_dec(i, beq);
        rs = int'(i[25:21]);
        rt = int'(i[20:16]);
        st = q[0].load && q[0].dest != 0 && (q[0].dest == rs || (q[0].dest == rt && d.rrt != 0));
        check("pc_src", 32'(pc_src), st ? 0 : d.pc);
        check("imm_ext", 32'(imm_ext), d.imm);
        check("exe_a_src", 32'(exe_a_src), d.a);
        check("exe_b_src", 32'(exe_b_src), d.b);
        check("exe_alu_oper", 32'(exe_alu_oper), d.alu);
        check("mem_ren", 32'(mem_ren), d.ren);
        check("mem_wen", 32'(mem_wen), d.mwen);
        check("wb_addr_src", 32'(wb_addr_src), d.wba);
        check("wb_data_src", 32'(wb_data_src), d.wbd);
        check("wb_wen", 32'(wb_wen), d.wbw);
        check("unrecognized", 32'(unrecognized), d.unrec);
        check("fwd_a", 32'(fwd_a), exp_fwd(rs));
        check("fwd_b", 32'(fwd_b), exp_fwd(rt));
        check("if_en", 32'(if_en), !st);
        check("id_en", 32'(id_en), !st);
        check("exe_bubble", 32'(exe_bubble), st);
        check("id_flush", 32'(id_flush), (d.xfer != 0) && !st);
        check("cpu_rst", 32'(cpu_rst), exp_rst);
        check("cpu_en", 32'(cpu_en), !exp_rst);
        cap_pc = 32'(pc_src); cap_flush = 32'(id_flush); cap_if = 32'(if_en);
        cap_bubble = 32'(exe_bubble); cap_fa = 32'(fwd_a); cap_fb = 32'(fwd_b);
        @(posedge clk);
        if (!exp_rst) begin
            p.dest = st ? 0 : d.dest;
            p.load = !st && d.ren != 0;
            q.push_front(p);
            void'(q.pop_back());
        end
        exp_rst = 0;
        @(negedge clk);
        stalled = st;
        flushed = (d.xfer != 0) && !st;
    endtask

    task automatic issue(input logic [31:0] i, input logic beq);
        bit st, fl;
        step(i, beq, st, fl);
        for (int k = 0; k < 3 && st; k++) step(i, beq, st, fl);
        check("stall_release", cap_if, 1);
        if (fl) step(32'h0, 1'b0, st, fl);
    endtask

    function automatic logic [31:0] rand_inst();
        int k, a, b, c, imm, fn;
        k   = $urandom_range(0, 12);
        a   = $urandom_range(0, 7);
        b   = $urandom_range(0, 7);
        c   = $urandom_range(0, 7);
        imm = $urandom_range(0, 65535);
        case ($urandom_range(0, 4))
            0: fn = 'h20;
            1: fn = 'h22;
            2: fn = 'h24;
            3: fn = 'h25;
            default: fn = 'h2A;
        endcase
        case (k)
            0:       return r_ins(fn, a, b, c);
            1:       return r_ins('h08, 0, b, 0);
            2:       return j_ins('h02, imm);
            3:       return j_ins('h03, imm);
            4:       return i_ins('h04, c, b, imm);
            5:       return i_ins('h08, a, b, imm);
            6:       return i_ins('h0C, a, b, imm);
            7:       return i_ins('h0D, a, b, imm);
            9:       return i_ins('h2B, c, b, imm);
            10:      return ($urandom_range(0, 1) != 0) ? i_ins('h3F, a, b, imm) : r_ins('h21, a, b, c);
            default: return i_ins('h23, a, b, imm);
        endcase
    endfunction

`ifdef CTRL_DEBUG_EN
    task automatic dbg_cycle(input logic stp, input int en, input int busy);
        prod_t p;
        inst       = '0;
        debug_step = stp;
        #1;
        check("dbg_cpu_en", 32'(cpu_en), en);
        check("dbg_busy", 32'(debug_busy), busy);
        @(posedge clk);
        if (en != 0) begin
            p.dest = 0;
            p.load = 0;
            q.push_front(p);
            void'(q.pop_back());
        end
        @(negedge clk);
    endtask
`endif

    initial begin
        bit st, fl;
        reset_model();
        exp_rst = 1;
        @(negedge clk);
        check("rst_cpu_rst", 32'(cpu_rst), 1);
        check("rst_cpu_en", 32'(cpu_en), 0);
        check("rst_fwd_a", 32'(fwd_a), 0);
        check("rst_if_en", 32'(if_en), 1);
        rst = 1'b0;
        #1;
        check("rel_cpu_rst", 32'(cpu_rst), 1);
        check("rel_cpu_en", 32'(cpu_en), 0);
        step(32'h0, 1'b0, st, fl);

        step(r_ins('h20, 3, 1, 2), 1'b0, st, fl);
        step(r_ins('h20, 4, 3, 1), 1'b0, st, fl);
        check("dir_fwd_exe", cap_fa, 1);
        check("dir_no_stall", cap_if, 1);

        step(i_ins('h23, 5, 0, 0), 1'b0, st, fl);
        step(r_ins('h20, 6, 5, 5), 1'b0, st, fl);
        check("dir_lu_if_en", cap_if, 0);
        check("dir_lu_bubble", cap_bubble, 1);
        step(r_ins('h20, 6, 5, 5), 1'b0, st, fl);
        check("dir_lu_fwd_a", cap_fa, 2);
        check("dir_lu_fwd_b", cap_fb, 2);
        check("dir_lu_resume", cap_if, 1);

        step(r_ins('h20, 0, 1, 2), 1'b0, st, fl);
        step(r_ins('h20, 7, 0, 1), 1'b0, st, fl);
        check("dir_zero_fwd", cap_fa, 0);

        step(j_ins('h02, 'h10), 1'b0, st, fl);
        check("dir_j_pc", cap_pc, 1);
        check("dir_j_flush", cap_flush, 1);
        step(32'h0, 1'b0, st, fl);
        check("dir_j_flush_once", cap_flush, 0);

        step(i_ins('h04, 2, 1, 8), 1'b0, st, fl);
        check("dir_beq_nt_pc", cap_pc, 0);
        check("dir_beq_nt_flush", cap_flush, 0);
        step(i_ins('h04, 2, 1, 8), 1'b1, st, fl);
        check("dir_beq_t_pc", cap_pc, 3);
        check("dir_beq_t_flush", cap_flush, 1);
        step(32'h0, 1'b0, st, fl);

        step(i_ins('h23, 3, 0, 4), 1'b0, st, fl);
        inst = r_ins('h20, 8, 3, 3);
        #1;
        check("pre_rst_stall", 32'(if_en), 0);
        #1 rst = 1'b1;
        #1;
        check("mid_rst_cpu_rst", 32'(cpu_rst), 1);
        check("mid_rst_cpu_en", 32'(cpu_en), 0);
        check("mid_rst_if_en", 32'(if_en), 1);
        check("mid_rst_bubble", 32'(exe_bubble), 0);
        reset_model();
        exp_rst = 1;
        @(negedge clk);
        rst = 1'b0;
        step(r_ins('h20, 8, 3, 3), 1'b0, st, fl);

`ifdef CTRL_DEBUG_EN
        step(32'h0, 1'b0, st, fl);
        debug_en = 1'b1;
        step(32'h0, 1'b0, st, fl);
        dbg_cycle(1'b0, 0, 0);
        debug_nsteps = 8'd3;
        dbg_cycle(1'b1, 0, 0);
        dbg_cycle(1'b0, 1, 1);
        dbg_cycle(1'b0, 1, 1);
        dbg_cycle(1'b0, 1, 1);
        dbg_cycle(1'b0, 0, 0);
        debug_nsteps = 8'd0;
        dbg_cycle(1'b1, 0, 0);
        dbg_cycle(1'b0, 1, 1);
        dbg_cycle(1'b0, 0, 0);
        debug_nsteps = 8'd5;
        dbg_cycle(1'b1, 0, 0);
        dbg_cycle(1'b0, 1, 1);
        #2 rst = 1'b1;
        debug_en = 1'b0;
        #1;
        check("dbg_rst_cpu_rst", 32'(cpu_rst), 1);
        check("dbg_rst_cpu_en", 32'(cpu_en), 0);
        check("dbg_rst_busy", 32'(debug_busy), 0);
        reset_model();
        exp_rst = 1;
        @(negedge clk);
        rst = 1'b0;
        step(32'h0, 1'b0, st, fl);
`endif

        for (int k = 0; k < 300; k++) issue(rand_inst(), 1'($urandom_range(0, 1)));

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
